lcd_driver: RTL

Back end of the character-LCD path. Accepts per-character write strobes (row, column, char) into a 2x16 shadow buffer at full clock rate, initialises an HD44780-compatible 16x2 panel in 4-bit mode after reset, and then scans the buffer to the panel continuously. It sits between the character producer (row/col/char/we source) and the board LCD pins.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_if.sv | 14 +
 rtl/lcd_nibble_tx.sv | 56 +++++
 rtl/lcd_driver.sv | 105 ++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state types, HD44780 command codes, init ROM and timing constants
package lcd_pkg;
   typedef enum logic [1:0] {S_PWR, S_INIT, S_ADDR, S_DATA} state_t;
   typedef enum logic [1:0] {PH_HI, PH_LO, PH_WAIT} phase_t;
   typedef enum logic [1:0] {N_IDLE, N_SETUP, N_EHIGH, N_GAP} nstate_t;
   localparam logic [7:0] CMD_FUNC  = 8'h28;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_DDRAM = 8'h80;
   localparam logic [7:0] ROW1_OFS  = 8'h40;
   localparam logic [7:0] SPACE     = 8'h20;
   localparam int T_PWR_US   = 15000;
   localparam int T_WAKE0_US = 4100;
   localparam int T_WAKE1_US = 100;
   localparam int T_CMD_US   = 40;
   localparam int T_CLEAR_US = 1640;
   function automatic logic [23:0] us_to_load(input int us, input int mhz);
      return 24'(us * mhz - 1);
   endfunction
   // Entries 0..3 are single wake-up nibbles carried in the high half.
   function automatic logic [7:0] init_val(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: return 8'h30;
         3'd3: return 8'h20;
         3'd4: return CMD_FUNC;
         3'd5: return CMD_DISP;
         3'd6: return CMD_ENTRY;
         default: return CMD_CLEAR;
      endcase
   endfunction
   function automatic int init_us(input logic [2:0] idx);
      return idx == 3'd0 ? T_WAKE0_US : idx == 3'd1 ? T_WAKE1_US : idx == 3'd7 ? T_CLEAR_US : T_CMD_US;
   endfunction
endpackage

// File: rtl/lcd_if.sv
// lcd_if: character write port plus the HD44780 pin bundle
interface lcd_if;
   logic       lcd_we;
   logic       lcd_row;
   logic [3:0] lcd_col;
   logic [7:0] lcd_char;
   logic       lcd_busy;
   logic [3:0] LCD_DB;
   logic       LCD_RS;
   logic       LCD_RW;
   logic       LCD_E;
   modport master (output lcd_we, lcd_row, lcd_col, lcd_char, input lcd_busy, LCD_DB, LCD_RS, LCD_RW, LCD_E);
   modport slave  (input lcd_we, lcd_row, lcd_col, lcd_char, output lcd_busy, LCD_DB, LCD_RS, LCD_RW, LCD_E);
endinterface

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: one 4-bit panel transfer as setup, E pulse and recovery gap
module lcd_nibble_tx
   import lcd_pkg::*;
#(parameter int CLK_MHZ = 50) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start_i,
   input  logic       rs_i,
   input  logic [3:0] nibble_i,
   output logic [3:0] lcd_db_o,
   output logic       lcd_rs_o,
   output logic       lcd_e_o,
   output logic       done_o
);
   localparam int E_HIGH = CLK_MHZ / 2 > 1 ? CLK_MHZ / 2 : 1;
   nstate_t    st_q, st_d;
   logic [9:0] cnt_q, cnt_d;
   logic [3:0] db_q, db_d;
   logic       rs_q, rs_d;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         st_q  <= N_IDLE;
         cnt_q <= '0;
         db_q  <= '0;
         rs_q  <= 1'b0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         db_q  <= db_d;
         rs_q  <= rs_d;
      end
   // DB/RS are only reloaded on start, so they never move while E is high.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q - 10'd1;
      db_d  = db_q;
      rs_d  = rs_q;
      if (start_i) begin
         st_d  = N_SETUP;
         cnt_d = 10'd1;
         db_d  = nibble_i;
         rs_d  = rs_i;
      end else if (cnt_q == '0)
         case (st_q)
            N_SETUP: begin st_d = N_EHIGH; cnt_d = 10'(E_HIGH - 1); end
            N_EHIGH: begin st_d = N_GAP; cnt_d = 10'(CLK_MHZ - 1); end
            default: begin st_d = N_IDLE; cnt_d = '0; end
         endcase
   end
   always_comb begin
      lcd_e_o  = st_q == N_EHIGH;
      done_o   = st_q == N_GAP && cnt_q == '0;
      lcd_db_o = db_q;
      lcd_rs_o = rs_q;
   end
endmodule

// File: rtl/lcd_driver.sv
// lcd_driver: 2x16 shadow buffer, HD44780 4-bit power-up init and continuous refresh scan
module lcd_driver
   import lcd_pkg::*;
#(parameter int CLK_MHZ = 50) (
   input logic CLK,
   input logic RST,
   lcd_if.slave bus
);
   state_t      st_q, st_d, nst;
   phase_t      ph_q, ph_d;
   logic [2:0]  idx_q, idx_d, nidx;
   logic        row_q, row_d, nrow;
   logic [3:0]  col_q, col_d, ncol;
   logic [23:0] cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [3:0]  lo_q, lo_d;
   logic [7:0]  buf_q [32];
   logic [7:0]  nbyte;
   logic [3:0]  tx_nib;
   logic        expired, done, start, tx_rs, is_byte;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) for (int i = 0; i < 32; i++) buf_q[i] <= SPACE;
      else if (bus.lcd_we) buf_q[{bus.lcd_row, bus.lcd_col}] <= bus.lcd_char;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         st_q   <= S_PWR;
         ph_q   <= PH_WAIT;
         idx_q  <= '0;
         row_q  <= 1'b0;
         col_q  <= '0;
         cnt_q  <= us_to_load(T_PWR_US, CLK_MHZ);
         busy_q <= 1'b1;
         lo_q   <= '0;
      end else begin
         st_q   <= st_d;
         ph_q   <= ph_d;
         idx_q  <= idx_d;
         row_q  <= row_d;
         col_q  <= col_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         lo_q   <= lo_d;
      end
   // Successor item, launched (and its buffer byte latched) the cycle the current wait expires.
   always_comb begin
      nst  = st_q;
      nidx = idx_q;
      nrow = row_q;
      ncol = col_q;
      case (st_q)
         S_PWR:  nst = S_INIT;
         S_INIT: begin nst = idx_q == 3'd7 ? S_ADDR : S_INIT; nidx = idx_q + 3'd1; end
         S_ADDR: begin nst = S_DATA; ncol = '0; end
         default: begin
            nst  = col_q == 4'd15 ? S_ADDR : S_DATA;
            nrow = col_q == 4'd15 ? ~row_q : row_q;
            ncol = col_q + 4'd1;
         end
      endcase
      nbyte   = nst == S_INIT ? init_val(nidx) : nst == S_ADDR ? (CMD_DDRAM | (nrow ? ROW1_OFS : 8'h00)) : buf_q[{nrow, ncol}];
      expired = ph_q == PH_WAIT && cnt_q == '0;
      is_byte = st_q != S_INIT || idx_q[2];
   end
   always_comb begin
      st_d   = st_q;
      ph_d   = ph_q;
      idx_d  = idx_q;
      row_d  = row_q;
      col_d  = col_q;
      busy_d = busy_q;
      lo_d   = lo_q;
      cnt_d  = ph_q == PH_WAIT && cnt_q != '0 ? cnt_q - 24'd1 : cnt_q;
      if (expired) begin
         st_d  = nst;
         ph_d  = PH_HI;
         idx_d = nidx;
         row_d = nrow;
         col_d = ncol;
         lo_d  = nbyte[3:0];
         if (st_q == S_INIT && idx_q == 3'd7) busy_d = 1'b0;
      end else if (done && ph_q == PH_HI && is_byte) ph_d = PH_LO;
      else if (done) begin
         ph_d  = PH_WAIT;
         cnt_d = us_to_load(st_q == S_INIT ? init_us(idx_q) : T_CMD_US, CLK_MHZ);
      end
   end
   always_comb begin
      start  = expired || (done && ph_q == PH_HI && is_byte);
      tx_nib = expired ? nbyte[7:4] : lo_q;
      tx_rs  = expired ? nst == S_DATA : st_q == S_DATA;
   end
   lcd_nibble_tx #(.CLK_MHZ(CLK_MHZ)) u_tx (
      .CLK      (CLK),
      .RST      (RST),
      .start_i  (start),
      .rs_i     (tx_rs),
      .nibble_i (tx_nib),
      .lcd_db_o (bus.LCD_DB),
      .lcd_rs_o (bus.LCD_RS),
      .lcd_e_o  (bus.LCD_E),
      .done_o   (done)
   );
   assign bus.lcd_busy = busy_q;
   assign bus.LCD_RW   = 1'b0;
endmodule
